// File: rtl/fib_arbiter.sv
// fib_arbiter: two-client round-robin front end for a Fibonacci recurrence (sum/prev_sum, one add per cycle).
// Optional build macro FIB_ARB_SAT_EN saturates sum to all ones once an add has carried out.
module fib_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int IDX_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid_0,
  input  logic                  req_valid_1,
  input  logic [IDX_WIDTH-1:0]  req_n_0,
  input  logic [IDX_WIDTH-1:0]  req_n_1,
  output logic                  req_ready_0,
  output logic                  req_ready_1,
  output logic                  rsp_valid_0,
  output logic                  rsp_valid_1,
  output logic [DATA_WIDTH-1:0] rsp_data_0,
  output logic [DATA_WIDTH-1:0] rsp_data_1,
  output logic                  rsp_ovf_0,
  output logic                  rsp_ovf_1,
  input  logic                  rsp_ready_0,
  input  logic                  rsp_ready_1
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic [DATA_WIDTH-1:0] sum, prev_sum, sum_nx;
  logic [DATA_WIDTH:0] add;
  logic [IDX_WIDTH-1:0] cnt;
  logic owner, ovf, rr_ptr, grant, hs, rsp_fire, step;
  always_comb begin
    grant = (rr_ptr ? req_valid_1 : req_valid_0) ? rr_ptr : ~rr_ptr;
    hs = (state == IDLE) && (req_valid_0 || req_valid_1);
    req_ready_0 = !reset && hs && !grant;
    req_ready_1 = !reset && hs && grant;
    rsp_fire = (state == RESP) && (owner ? rsp_ready_1 : rsp_ready_0);
    step = (state == BUSY) && (cnt != '0);
    add = {1'b0, sum} + {1'b0, prev_sum};
`ifdef FIB_ARB_SAT_EN
    sum_nx = (ovf || add[DATA_WIDTH]) ? '1 : add[DATA_WIDTH-1:0];
`else
    sum_nx = add[DATA_WIDTH-1:0];
`endif
    state_nx = hs ? BUSY
             : (state == BUSY && cnt == '0) ? RESP
             : rsp_fire ? IDLE
             : state;
    rsp_valid_0 = (state == RESP) && !owner;
    rsp_valid_1 = (state == RESP) && owner;
    rsp_data_0 = rsp_valid_0 ? sum : '0;
    rsp_data_1 = rsp_valid_1 ? sum : '0;
    rsp_ovf_0 = rsp_valid_0 && ovf;
    rsp_ovf_1 = rsp_valid_1 && ovf;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      sum <= DATA_WIDTH'(1);
      prev_sum <= DATA_WIDTH'(1);
      cnt <= '0;
      owner <= 1'b0;
      ovf <= 1'b0;
      rr_ptr <= 1'b0;
    end else begin
      state <= state_nx;
      if (hs) begin
        sum <= DATA_WIDTH'(1);
        prev_sum <= DATA_WIDTH'(1);
        ovf <= 1'b0;
        cnt <= grant ? req_n_1 : req_n_0;
        owner <= grant;
      end else if (step) begin
        prev_sum <= sum;
        sum <= sum_nx;
        ovf <= ovf | add[DATA_WIDTH];
        cnt <= cnt - 1'b1;
      end
      if (rsp_fire) rr_ptr <= ~owner;
    end
  end
endmodule

// File: tb/tb_fib_arbiter.sv
// tb_fib_arbiter: directed and randomized checks of fib_arbiter at DATA_WIDTH=8 against a true-Fibonacci model.
module tb_fib_arbiter;
  localparam int DW = 8;
  localparam int IW = 6;
  logic clk = 0, reset = 1;
  logic req_valid_0 = 0, req_valid_1 = 0, rsp_ready_0 = 0, rsp_ready_1 = 0;
  logic [IW-1:0] req_n_0 = '0, req_n_1 = '0;
  logic req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_ovf_0, rsp_ovf_1;
  logic [DW-1:0] rsp_data_0, rsp_data_1;
  int n_checks = 0, n_fail = 0;

  fib_arbiter #(.DATA_WIDTH(DW), .IDX_WIDTH(IW)) dut (
    .clk(clk), .reset(reset),
    .req_valid_0(req_valid_0), .req_valid_1(req_valid_1),
    .req_n_0(req_n_0), .req_n_1(req_n_1),
    .req_ready_0(req_ready_0), .req_ready_1(req_ready_1),
    .rsp_valid_0(rsp_valid_0), .rsp_valid_1(rsp_valid_1),
    .rsp_data_0(rsp_data_0), .rsp_data_1(rsp_data_1),
    .rsp_ovf_0(rsp_ovf_0), .rsp_ovf_1(rsp_ovf_1),
    .rsp_ready_0(rsp_ready_0), .rsp_ready_1(rsp_ready_1)
  );

  always #5 clk = ~clk;

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // Reference: exact Fibonacci term; any carry out of DW bits happens the first time the true value exceeds DW bits.
  function automatic void model(input int n, output logic [DW-1:0] d, output logic o);
    longint a = 1, b = 1, t;
    for (int k = 0; k < n; k++) begin
      t = a + b;
      b = a;
      a = t;
    end
    o = a >= (longint'(1) << DW);
`ifdef FIB_ARB_SAT_EN
    d = o ? '1 : DW'(a);
`else
    d = DW'(a);
`endif
  endfunction

  function automatic logic [7:0] all_outs();
    return {req_ready_0, req_ready_1, rsp_valid_0, rsp_valid_1, rsp_ovf_0, rsp_ovf_1, |rsp_data_0, |rsp_data_1};
  endfunction

  // Stimulus only: starts at a negedge, issues one request, returns wait, latency, data and ovf, ends at a negedge.
  task automatic do_req(input bit p, input int n, input int hold, output int wt, output int lat,
                        output logic [DW-1:0] d, output logic o, output bit ok);
    ok = 1; wt = 0; lat = 0; d = '0; o = 0;
    if (p) begin req_valid_1 = 1; req_n_1 = IW'(n); end
    else begin req_valid_0 = 1; req_n_0 = IW'(n); end
    #1;
    while (!(p ? req_ready_1 : req_ready_0) && wt < 100) begin @(negedge clk); #1; wt++; end
    if (!(p ? req_ready_1 : req_ready_0)) ok = 0;
    @(negedge clk);
    if (p) req_valid_1 = 0; else req_valid_0 = 0;
    #1; lat = 1;
    while (!(p ? rsp_valid_1 : rsp_valid_0) && lat < 200) begin @(negedge clk); #1; lat++; end
    if (!(p ? rsp_valid_1 : rsp_valid_0)) ok = 0;
    d = p ? rsp_data_1 : rsp_data_0;
    o = p ? rsp_ovf_1 : rsp_ovf_0;
    repeat (hold) @(negedge clk);
    if (p) rsp_ready_1 = 1; else rsp_ready_0 = 1;
    @(negedge clk);
    rsp_ready_0 = 0; rsp_ready_1 = 0;
  endtask

  task automatic test_reset();
    reset = 1; req_valid_0 = 1;
    repeat (2) @(negedge clk);
    #1;
    n_checks++;
    if (all_outs() !== 8'h00) begin n_fail++; $display("FAIL reset_outputs: got %b want 00000000", all_outs()); end
    req_valid_0 = 0;
    @(negedge clk);
    reset = 0;
  endtask

  task automatic test_simultaneous();
    int cyc = 0, early = 0;
    req_valid_0 = 1; req_n_0 = 3; req_valid_1 = 1; req_n_1 = 5;
    #1;
    n_checks++;
    if ({req_ready_0, req_ready_1} !== 2'b10) begin n_fail++; $display("FAIL sim_grant: ready=%b want 10", {req_ready_0, req_ready_1}); end
    @(negedge clk); req_valid_0 = 0; #1;
    while (!rsp_valid_0 && cyc < 50) begin
      if (req_ready_1) early++;
      @(negedge clk); #1; cyc++;
    end
    if (req_ready_1) early++;
    n_checks++;
    if (!rsp_valid_0 || rsp_data_0 !== 8'd5) begin n_fail++; $display("FAIL sim_p0_data: valid=%b data=%0d want 1/5", rsp_valid_0, rsp_data_0); end
    n_checks++;
    if (early != 0) begin n_fail++; $display("FAIL sim_p1_blocked: req_ready_1 high %0d cycles, want 0", early); end
    rsp_ready_0 = 1;
    @(negedge clk); rsp_ready_0 = 0; #1;
    n_checks++;
    if (req_ready_1 !== 1'b1) begin n_fail++; $display("FAIL sim_p1_grant: req_ready_1=%b want 1", req_ready_1); end
    @(negedge clk); req_valid_1 = 0; #1;
    cyc = 0;
    while (!rsp_valid_1 && cyc < 50) begin @(negedge clk); #1; cyc++; end
    n_checks++;
    if (!rsp_valid_1 || rsp_data_1 !== 8'd13) begin n_fail++; $display("FAIL sim_p1_data: valid=%b data=%0d want 1/13", rsp_valid_1, rsp_data_1); end
    rsp_ready_1 = 1;
    @(negedge clk); rsp_ready_1 = 0;
  endtask

  task automatic test_single();
    int wt, lat; logic [DW-1:0] d; logic o; bit ok;
    do_req(0, 4, 0, wt, lat, d, o, ok);
    n_checks++;
    if (!ok || wt != 0 || lat != 6 || d !== 8'd8 || o !== 1'b0) begin
      n_fail++; $display("FAIL p0_n4: ok=%0d wait=%0d lat=%0d data=%0d ovf=%b want 1/0/6/8/0", ok, wt, lat, d, o);
    end
    do_req(1, 0, 0, wt, lat, d, o, ok);
    n_checks++;
    if (!ok || lat != 2 || d !== 8'd1) begin n_fail++; $display("FAIL p1_n0: ok=%0d lat=%0d data=%0d want 1/2/1", ok, lat, d); end
    do_req(1, 1, 0, wt, lat, d, o, ok);
    n_checks++;
    if (!ok || lat != 3 || d !== 8'd2) begin n_fail++; $display("FAIL p1_n1: ok=%0d lat=%0d data=%0d want 1/3/2", ok, lat, d); end
  endtask

  task automatic test_overflow();
    int wt, lat; logic [DW-1:0] d, ed; logic o, eo; bit ok;
    do_req(0, 11, 0, wt, lat, d, o, ok);
    n_checks++;
    if (!ok || d !== 8'd233 || o !== 1'b0) begin n_fail++; $display("FAIL ovf_n11: data=%0d ovf=%b want 233/0", d, o); end
    model(12, ed, eo);
    do_req(1, 12, 0, wt, lat, d, o, ok);
    n_checks++;
    if (!ok || d !== ed || o !== 1'b1) begin n_fail++; $display("FAIL ovf_n12: data=%0d ovf=%b want %0d/1", d, o, ed); end
  endtask

  task automatic test_backpressure();
    int cyc = 0, bad = 0; logic [DW-1:0] held;
    req_valid_0 = 1; req_n_0 = 2; #1;
    @(negedge clk); req_valid_0 = 0; #1;
    while (!rsp_valid_0 && cyc < 50) begin @(negedge clk); #1; cyc++; end
    held = rsp_data_0;
    req_valid_1 = 1; req_n_1 = 1;
    repeat (5) begin
      #1;
      if (!rsp_valid_0 || rsp_data_0 !== held || req_ready_1) bad++;
      @(negedge clk);
    end
    n_checks++;
    if (held !== 8'd3 || bad != 0) begin n_fail++; $display("FAIL bp_hold: data=%0d unstable_cycles=%0d want 3/0", held, bad); end
    rsp_ready_0 = 1;
    @(negedge clk); rsp_ready_0 = 0; #1;
    n_checks++;
    if (req_ready_1 !== 1'b1 || rsp_valid_0 !== 1'b0) begin
      n_fail++; $display("FAIL bp_release: req_ready_1=%b rsp_valid_0=%b want 1/0", req_ready_1, rsp_valid_0);
    end
    @(negedge clk); req_valid_1 = 0; #1;
    cyc = 0;
    while (!rsp_valid_1 && cyc < 50) begin @(negedge clk); #1; cyc++; end
    n_checks++;
    if (!rsp_valid_1 || rsp_data_1 !== 8'd2) begin n_fail++; $display("FAIL bp_p1_data: valid=%b data=%0d want 1/2", rsp_valid_1, rsp_data_1); end
    rsp_ready_1 = 1;
    @(negedge clk); rsp_ready_1 = 0;
  endtask

  task automatic test_back_to_back();
    int wt, lat; logic [DW-1:0] d; logic o; bit ok;
    do_req(1, 3, 0, wt, lat, d, o, ok);
    do_req(1, 2, 0, wt, lat, d, o, ok);
    n_checks++;
    if (!ok || wt != 0 || d !== 8'd3) begin n_fail++; $display("FAIL b2b: ok=%0d wait=%0d data=%0d want 1/0/3", ok, wt, d); end
  endtask

  task automatic test_reset_mid();
    int seen = 0, wt, lat; logic [DW-1:0] d; logic o; bit ok;
    req_valid_0 = 1; req_n_0 = 20; #1;
    @(negedge clk); req_valid_0 = 0;
    repeat (5) @(negedge clk);
    req_valid_0 = 1;
    #2 reset = 1;
    #1;
    n_checks++;
    if (all_outs() !== 8'h00) begin n_fail++; $display("FAIL mid_reset_outputs: got %b want 00000000", all_outs()); end
    req_valid_0 = 0;
    repeat (2) @(negedge clk);
    reset = 0;
    repeat (30) begin
      @(negedge clk); #1;
      if (rsp_valid_0 || rsp_valid_1) seen++;
    end
    n_checks++;
    if (seen != 0) begin n_fail++; $display("FAIL mid_reset_no_rsp: rsp_valid seen %0d cycles want 0", seen); end
    @(negedge clk);
    do_req(0, 2, 0, wt, lat, d, o, ok);
    n_checks++;
    if (!ok || d !== 8'd3) begin n_fail++; $display("FAIL mid_reset_recover: ok=%0d data=%0d want 1/3", ok, d); end
  endtask

  task automatic test_random();
    int wt, lat, n, hold; bit p, ok; logic [DW-1:0] d, ed; logic o, eo;
    for (int i = 0; i < 25; i++) begin
      p = 1'($urandom_range(0, 1));
      n = $urandom_range(0, 16);
      hold = $urandom_range(0, 3);
      model(n, ed, eo);
      do_req(p, n, hold, wt, lat, d, o, ok);
      n_checks++;
      if (!ok || lat != n + 2 || d !== ed || o !== eo) begin
        n_fail++; $display("FAIL rand[%0d] p%0d n=%0d: ok=%0d lat=%0d data=%0d ovf=%b want lat=%0d data=%0d ovf=%b",
                           i, p, n, ok, lat, d, o, n + 2, ed, eo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_simultaneous();
    test_single();
    test_overflow();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
